// File: rtl/fir_pkg.sv
// Shared helpers for the pipelined FIR: adder-tree sizing, accumulator width and
// the round-half-up / saturate function used by the saturating output stage.
package fir_pkg;
    localparam int SR_WIDTH = 128;

    function automatic int tree_lvls(input int n_taps);
        return (n_taps < 2) ? 1 : $clog2(n_taps);
    endfunction

    function automatic int acc_width(input int d_w, input int c_w, input int n_taps);
        return d_w + c_w + tree_lvls(n_taps);
    endfunction

    // The caller sign-extends the accumulator to SR_WIDTH, so the rounding add cannot overflow.
    function automatic logic signed [SR_WIDTH-1:0] sat_round(
        input  logic signed [SR_WIDTH-1:0] acc,
        input  int                         shift,
        input  int                         out_w,
        output logic                       sat
    );
        logic signed [SR_WIDTH-1:0] v;
        logic signed [SR_WIDTH-1:0] hi;
        logic signed [SR_WIDTH-1:0] lo;
        v = acc;
        if (shift > 0) begin
            v = v + (SR_WIDTH'(1) <<< (shift - 1));
        end
        v   = v >>> shift;
        hi  = (SR_WIDTH'(1) <<< (out_w - 1)) - SR_WIDTH'(1);
        lo  = -(SR_WIDTH'(1) <<< (out_w - 1));
        sat = 1'b0;
        if (v > hi) begin
            v   = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            v   = lo;
            sat = 1'b1;
        end
        return v;
    endfunction
endpackage

// File: rtl/fir_tree_param_if.sv
// Sample, coefficient-load and result signals of the FIR grouped as one bundle.
interface fir_tree_param_if #(
    parameter int N_TAPS      = 8,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int OUT_WIDTH   = 36
);
    localparam int ADDR_W = (N_TAPS < 2) ? 1 : $clog2(N_TAPS);

    logic                          ena;
    logic                          in_valid;
    logic signed [DATA_WIDTH-1:0]  data_in;
    logic                          coef_wr;
    logic [ADDR_W-1:0]             coef_addr;
    logic signed [COEFF_WIDTH-1:0] coef_data;
    logic                          coef_swap;
    logic                          out_valid;
    logic signed [OUT_WIDTH-1:0]   data_out;
    logic                          sat_flag;

    modport master (
        output ena, in_valid, data_in, coef_wr, coef_addr, coef_data, coef_swap,
        input  out_valid, data_out, sat_flag
    );

    modport slave (
        input  ena, in_valid, data_in, coef_wr, coef_addr, coef_data, coef_swap,
        output out_valid, data_out, sat_flag
    );
endinterface

// File: rtl/fir_adder_tree.sv
// Registered binary adder tree stored as a 0-based heap: node i sums nodes 2i+1 and 2i+2,
// so every level is one register stage and the root appears after log2(LEAVES) enabled edges.
module fir_adder_tree #(
    parameter int LEAVES = 8,
    parameter int WIDTH  = 38
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ena_i,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] leaves_i [LEAVES],
    output logic                    valid_o,
    output logic signed [WIDTH-1:0] sum_o
);
    localparam int LVLS  = $clog2(LEAVES);
    localparam int NODES = LEAVES - 1;

    logic signed [WIDTH-1:0] sum_q [NODES];
    logic signed [WIDTH-1:0] node  [2*LEAVES-1];
    logic [LVLS-1:0]         vld_q;

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_int
            assign node[gi] = sum_q[gi];
        end
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            assign node[NODES + gi] = leaves_i[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NODES; i++) begin
                sum_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (ena_i) begin
            for (int i = 0; i < NODES; i++) begin
                sum_q[i] <= node[2*i+1] + node[2*i+2];
            end
            vld_q <= LVLS'({vld_q, valid_i});
        end
    end

    assign valid_o = vld_q[LVLS-1];
    assign sum_o   = sum_q[0];
endmodule

// File: rtl/fir_tree_param.sv
// N-tap pipelined FIR: delay line, double-buffered coefficients, registered products,
// registered adder tree and output register. FIR_SAT_EN selects round+saturate output.
module fir_tree_param
    import fir_pkg::*;
#(
    parameter int N_TAPS      = 8,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int OUT_WIDTH   = 36,
    parameter int OUT_SHIFT   = 0
) (
    input logic             clk,
    input logic             reset_n,
    fir_tree_param_if.slave bus
);
    localparam int TREE_LVLS = tree_lvls(N_TAPS);
    localparam int LEAVES    = 1 << TREE_LVLS;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);

    typedef logic signed [COEFF_WIDTH-1:0] coef_bank_t [N_TAPS];

    logic signed [DATA_WIDTH-1:0] delay_q [N_TAPS];
    coef_bank_t                   shadow_q;
    coef_bank_t                   active_q;
    logic signed [ACC_WIDTH-1:0]  prod_q  [N_TAPS];
    logic signed [ACC_WIDTH-1:0]  leaves  [LEAVES];
    logic                         dl_vld_q;
    logic                         prod_vld_q;
    logic                         tree_vld;
    logic signed [ACC_WIDTH-1:0]  tree_sum;
    logic signed [OUT_WIDTH-1:0]  out_q;
    logic signed [OUT_WIDTH-1:0]  out_d;
    logic                         sat_q;
    logic                         sat_d;
    logic                         ov_q;
    logic                         addr_ok;

    assign addr_ok = (32'(bus.coef_addr) < N_TAPS);

    // Coefficient banks ignore ena; a same-cycle write lands only in the shadow bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (bus.coef_swap) begin
                active_q <= shadow_q;
            end
            if (bus.coef_wr && addr_ok) begin
                shadow_q[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                delay_q[k] <= '0;
                prod_q[k]  <= '0;
            end
            dl_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
            out_q      <= '0;
            sat_q      <= 1'b0;
            ov_q       <= 1'b0;
        end else if (bus.ena) begin
            if (bus.in_valid) begin
                delay_q[0] <= bus.data_in;
                for (int k = 1; k < N_TAPS; k++) begin
                    delay_q[k] <= delay_q[k-1];
                end
            end
            dl_vld_q <= bus.in_valid;
            // All taps multiply in one stage, so a result never mixes coefficient banks.
            for (int k = 0; k < N_TAPS; k++) begin
                prod_q[k] <= ACC_WIDTH'(delay_q[k]) * ACC_WIDTH'(active_q[k]);
            end
            prod_vld_q <= dl_vld_q;
            out_q      <= out_d;
            sat_q      <= sat_d && tree_vld;
            ov_q       <= tree_vld;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_pad
            if (gi < N_TAPS) begin : g_tap
                assign leaves[gi] = prod_q[gi];
            end else begin : g_zero
                assign leaves[gi] = '0;
            end
        end
    endgenerate

    fir_adder_tree #(
        .LEAVES (LEAVES),
        .WIDTH  (ACC_WIDTH)
    ) u_tree (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena_i    (bus.ena),
        .valid_i  (prod_vld_q),
        .leaves_i (leaves),
        .valid_o  (tree_vld),
        .sum_o    (tree_sum)
    );

    always_comb begin
        out_d = '0;
        sat_d = 1'b0;
`ifdef FIR_SAT_EN
        out_d = OUT_WIDTH'(sat_round(SR_WIDTH'(tree_sum), OUT_SHIFT, OUT_WIDTH, sat_d));
`else
        out_d = OUT_WIDTH'(tree_sum >>> OUT_SHIFT);
`endif
    end

    assign bus.out_valid = ov_q;
    assign bus.data_out  = out_q;
    assign bus.sat_flag  = sat_q;
endmodule
